multichannel_comb: RTL
======================

# multichannel_comb

Parametrised, time-multiplexed comb (differentiator) stage: for each accepted sample on channel c it outputs y = x[n] − x[n−DELAY] of that channel, with one bit of growth. It serves interleaved CIC decimator/interpolator chains and edge/slope detectors in the user-project datapath. Samples arrive as a round-robin stream of CHANNELS channels over a valid/ready handshake. Per-channel history is held in an internal DELAY-deep delay line.

## Interface
- WIDTH, 8: input sample width (≥2).
- DELAY, 1: differential delay M in samples per channel (1..8).
- CHANNELS, 1: interleaved channel count (1..8).
- SIGNED, 1: 1 = samples are two's complement (sign-extend); 0 = unsigned (zero-extend).
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- in_first  input  1  qualifies in_valid; marks the sample as channel 0 (frame realign).
- in_data  input  WIDTH  sample.
- hold  input  1  sample is differenced, but the history of its channel is not updated.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH+1  two's-complement difference.
- out_channel  output  CH_W  channel of out_data; CH_W = max(1, clog2(CHANNELS)).

## Operation
- Accept: a sample is accepted when in_valid && in_ready.
- Channel: the accepted channel is 0 when in_first=1, otherwise ch_cnt.
  - After acceptance, ch_cnt = accepted channel + 1, wrapping CHANNELS−1 → 0.
  - When CHANNELS=1, ch_cnt stays 0.
- History: each channel has DELAY entries h[c][0..DELAY−1]. h[c][DELAY−1] is the oldest.
- Difference: out = ext(in_data) − ext(h[c][DELAY−1]), computed in WIDTH+1 bits. ext is sign- or zero-extension per SIGNED.
  - The result cannot overflow and never wraps or saturates.
- History update on acceptance with hold=0: h[c] shifts and h[c][0] = in_data.
- History update on acceptance with hold=1: h[c] is unchanged; ch_cnt still advances.
- Other channels' history is never touched by an access to channel c.
- Reset values:
  - all h = 0, ch_cnt = 0;
  - out_valid = 0, out_data = 0, out_channel = 0.
- After reset, the first DELAY samples per channel are differenced against 0.

## Timing
- Latency is 1 cycle: a sample accepted at edge k appears on out_* after edge k, registered.
- in_ready = !out_valid || out_ready. This is combinational from out_ready only and gives full throughput of 1 sample/cycle.
- Output register update at each edge:
  - loads on acceptance;
  - clears out_valid when out_valid && out_ready and no new sample is accepted.
- Stall: out_data and out_channel hold stable while out_valid && !out_ready.
- Simultaneous handshake: a simultaneous output handshake and input accept in the same cycle replace the output with no bubble.
- Ignored inputs: in_first, hold and in_data are ignored unless in_valid && in_ready.
- reset mid-stream: effective at the next edge, and dominates everything else.
  - Any pending output is dropped (out_valid = 0).
  - History and counter are zeroed.
  - in_ready is 1 in the following cycle.
- No combinational path from in_* to out_*.

## Structure
- Package comb_pkg:
  - function ch_width(CHANNELS);
  - function ext(value, SIGNED) for WIDTH→WIDTH+1 extension.
- Sub-module comb_history (parameters WIDTH, DELAY, CHANNELS):
  - per-channel shift register array;
  - channel-indexed read of the oldest entry;
  - write-enable shift of the addressed channel.
- Top: channel counter, subtractor, output register/handshake.

## Test plan
- WIDTH=8, SIGNED=1, DELAY=1, CHANNELS=1; inputs 5, 3, −128, 127 with out_ready=1 -> outputs 5, −2, −131, 255, each 1 cycle after its input, 9-bit, no wrap.
- DELAY=2, CHANNELS=2, in_first on first sample; A0=10, B0=20, A1=11, B1=25, A2=15, B2=19 -> channels 0,1,0,1,0,1 and outputs 10, 20, 11, 25, 5, −1.
- hold=1 on input 7 after history {4} (DELAY=1), then input 9 with hold=0 -> outputs 3, then 5 (history stays 4); ch_cnt still advances.
- Backpressure: out_ready=0 for 3 cycles during a continuous in_valid stream -> in_ready=0 while stalled, out_data stable, no sample lost or duplicated, 1/cycle once released.
- in_first asserted while ch_cnt=2 (CHANNELS=4) -> that sample tagged channel 0 and uses channel 0 history; next sample tagged channel 1.
- reset asserted with out_valid=1 and nonzero history; then sample 6 -> out_valid=0 after reset edge, then output 6 on channel 0. Repeat with SIGNED=0 and input 255 after reset -> output +255.

Source files
------------

// File: rtl/comb_pkg.sv
// Shared helpers for the multichannel comb stage: channel index width and
// WIDTH -> WIDTH+1 sign/zero extension of samples.
package comb_pkg;

    localparam int EXT_MAX_WIDTH = 32;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Bits at and above position 'width' are filled with the sample's sign when is_signed is set.
    function automatic logic [EXT_MAX_WIDTH:0] ext(
        input logic [EXT_MAX_WIDTH-1:0] value,
        input int                       width,
        input logic                     is_signed
    );
        logic [EXT_MAX_WIDTH:0] one_w;
        logic [EXT_MAX_WIDTH:0] wide;
        logic [EXT_MAX_WIDTH:0] upper;
        logic                   fill;
        one_w = {{EXT_MAX_WIDTH{1'b0}}, 1'b1};
        wide  = {1'b0, value};
        upper = ~((one_w << width) - one_w);
        fill  = is_signed & (|((wide >> (width - 1)) & one_w));
        return fill ? (wide | upper) : wide;
    endfunction

endpackage

// File: rtl/comb_history.sv
// Per-channel DELAY-deep sample history: read of the oldest entry of one
// channel and shift-in of a new sample into the addressed channel.
module comb_history
    import comb_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int DELAY    = 1,
    parameter  int CHANNELS = 1,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CH_W-1:0]  rd_channel,
    output logic [WIDTH-1:0] oldest,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_channel,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] hist_r [CHANNELS][DELAY];

    assign oldest = hist_r[rd_channel][DELAY-1];

    // Shift register per channel; only the written channel moves.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int d = 0; d < DELAY; d++) begin
                    hist_r[c][d] <= {WIDTH{1'b0}};
                end
            end
        end else if (wr_en) begin
            for (int d = DELAY - 1; d > 0; d--) begin
                hist_r[wr_channel][d] <= hist_r[wr_channel][d-1];
            end
            hist_r[wr_channel][0] <= wr_data;
        end else begin
            hist_r <= hist_r;
        end
    end

endmodule

// File: rtl/multichannel_comb.sv
// Time-multiplexed comb stage: y = x[n] - x[n-DELAY] per interleaved channel,
// one bit of growth, one-cycle registered latency with valid/ready handshake.
module multichannel_comb
    import comb_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int DELAY    = 1,
    parameter  int CHANNELS = 1,
    parameter  int SIGNED   = 1,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [WIDTH-1:0] in_data,
    input  logic             hold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data,
    output logic [CH_W-1:0]  out_channel
);

    logic             accept_s;
    logic [CH_W-1:0]  acc_channel_s;
    logic [CH_W-1:0]  next_cnt_s;
    logic [WIDTH-1:0] oldest_s;
    logic [WIDTH:0]   diff_s;
    logic [CH_W-1:0]  ch_cnt_r;
    logic             out_valid_r;
    logic [WIDTH:0]   out_data_r;
    logic [CH_W-1:0]  out_channel_r;

    assign in_ready    = !out_valid_r || out_ready;
    assign accept_s    = in_valid && in_ready;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_channel = out_channel_r;

    // Channel of the current sample and the counter value that follows it.
    always_comb begin
        acc_channel_s = in_first ? {CH_W{1'b0}} : ch_cnt_r;
        next_cnt_s    = {CH_W{1'b0}};
        if (CHANNELS == 1) begin
            next_cnt_s = {CH_W{1'b0}};
        end else if (acc_channel_s == CH_W'(CHANNELS - 1)) begin
            next_cnt_s = {CH_W{1'b0}};
        end else begin
            next_cnt_s = acc_channel_s + {{(CH_W-1){1'b0}}, 1'b1};
        end
    end

    // Both operands are widened to WIDTH+1 first, so the difference can never wrap.
    assign diff_s = (WIDTH+1)'(ext(EXT_MAX_WIDTH'(in_data), WIDTH, SIGNED != 0)
                             - ext(EXT_MAX_WIDTH'(oldest_s), WIDTH, SIGNED != 0));

    comb_history #(
        .WIDTH    (WIDTH),
        .DELAY    (DELAY),
        .CHANNELS (CHANNELS)
    ) u_history (
        .clock      (clock),
        .reset      (reset),
        .rd_channel (acc_channel_s),
        .oldest     (oldest_s),
        .wr_en      (accept_s && !hold),
        .wr_channel (acc_channel_s),
        .wr_data    (in_data)
    );

    // Channel counter and output register with handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            ch_cnt_r      <= {CH_W{1'b0}};
            out_valid_r   <= 1'b0;
            out_data_r    <= {(WIDTH+1){1'b0}};
            out_channel_r <= {CH_W{1'b0}};
        end else if (accept_s) begin
            ch_cnt_r      <= next_cnt_s;
            out_valid_r   <= 1'b1;
            out_data_r    <= diff_s;
            out_channel_r <= acc_channel_s;
        end else if (out_ready) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

endmodule
